// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: two-requester controller for the 4x4 single-port memory.
// Each requester issues read/write commands over a valid/ready handshake.
// The controller runs one memory access at a time and returns a one-cycle
// response pulse to the requester that issued the command. For a write,
// the response carries the word the location held before the write.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN. When it is defined,
// requester 0 always wins a tie. When it is undefined, ties are resolved
// round-robin.
module mem_arb_ctrl #(
    parameter int AW = 2,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req1_valid,
    input  logic          req0_we,
    input  logic          req1_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic [DW-1:0] req1_wdata,
    output logic          req0_ready,
    output logic          req1_ready,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          rsp0_valid_q, rsp0_valid_d;
    logic          rsp1_valid_q, rsp1_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          pick0, pick1;
    logic          prefer0;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign prefer0 = 1'b1;
`else
    logic          prio_q, prio_d;
    assign prefer0 = ~prio_q;
`endif

    // Arbitration: a lone requester always wins; on a tie the preferred one wins.
    always_comb begin
        pick0 = req0_valid & (~req1_valid | prefer0);
        pick1 = req1_valid & ~pick0;
        req0_ready = (state_q == IDLE) & ~rst & pick0;
        req1_ready = (state_q == IDLE) & ~rst & pick1;
    end

    // Next-state logic: latch the command, present it for one cycle, then capture the memory output.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp_data_d   = rsp_data_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        prio_d       = prio_q;
`endif
        case (state_q)
            IDLE: begin
                mem_we_d = 1'b0;
                if (req0_ready || req1_ready) begin
                    owner_d     = req1_ready;
                    mem_we_d    = req1_ready ? req1_we    : req0_we;
                    mem_addr_d  = req1_ready ? req1_addr  : req0_addr;
                    mem_wdata_d = req1_ready ? req1_wdata : req0_wdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    prio_d      = ~req1_ready;
`endif
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                mem_we_d = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                rsp_data_d   = mem_data_out;
                rsp0_valid_d = ~owner_q;
                rsp1_valid_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers. A synchronous reset aborts any access that is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_data_q   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            prio_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp_data_q   <= rsp_data_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            prio_q       <= prio_d;
`endif
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_address = mem_addr_q;
    assign mem_data_in = mem_wdata_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp_data    = rsp_data_q;

endmodule
